// File: rtl/im_loader_pkg.sv
// ---------------------------------------------------------------------------
// im_loader_pkg
// Shared constants for the instruction-memory loader: memory geometry,
// byte/word widths and the loader FSM state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package im_loader_pkg;

    // Target instruction memory geometry
    localparam int IM_DEPTH = 64;
    localparam int IM_AW    = 6;

    // Datapath widths
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BCNT_W         = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    // Loader FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/im_loader_if.sv
// ---------------------------------------------------------------------------
// im_loader_if
// Bundles the control, byte-stream and memory-write signals of the loader.
// Ports (signals):
//   Start, Count, Abort        : load request / cancel from the controller
//   ByteValid, ByteData        : program byte stream from the source
//   ByteReady                  : loader accepts the current byte
//   WrEn, WrAddr, WrData       : instruction-memory write port
//   Busy, Done, Err            : loader status
// Modports: master = controller/source side, slave = loader side.
// ---------------------------------------------------------------------------
interface im_loader_if #(parameter int AW = im_loader_pkg::IM_AW);
    import im_loader_pkg::*;

    logic          Start;
    logic [AW:0]   Count;
    logic          Abort;
    logic          ByteValid;
    byte_t         ByteData;
    logic          ByteReady;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    word_t         WrData;
    logic          Busy;
    logic          Done;
    logic          Err;

    modport master (
        output Start, Count, Abort, ByteValid, ByteData,
        input  ByteReady, WrEn, WrAddr, WrData, Busy, Done, Err
    );

    modport slave (
        input  Start, Count, Abort, ByteValid, ByteData,
        output ByteReady, WrEn, WrAddr, WrData, Busy, Done, Err
    );

endinterface

// File: rtl/im_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects four bytes into one little-endian 32-bit word.
// Ports:
//   Clk, Reset  : clock, synchronous active-high reset
//   i_Clear     : restart assembly (counter and word to zero)
//   i_Push      : accept i_Byte this cycle
//   i_Byte      : incoming byte
//   o_Word      : assembled word (first pushed byte ends up in [7:0])
//   o_Full      : high in the cycle the last byte of a word is pushed
// ---------------------------------------------------------------------------
module byte_packer
    import im_loader_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    input  logic  i_Clear,
    input  logic  i_Push,
    input  byte_t i_Byte,
    output word_t o_Word,
    output logic  o_Full
);

    logic [BCNT_W-1:0] r_ByteCnt;
    word_t             r_Word;

    // Bytes shift in from the top, so after four pushes the first byte
    // has travelled down to bits [7:0].
    always_ff @(posedge Clk) begin
        if (Reset || i_Clear) begin
            r_ByteCnt <= '0;
            r_Word    <= '0;
        end else if (i_Push) begin
            r_ByteCnt <= r_ByteCnt + BCNT_W'(1);
            r_Word    <= {i_Byte, r_Word[WORD_W-1:BYTE_W]};
        end
    end

    // Combinational so the FSM can leave RECV on the same edge that
    // captures the final byte.
    assign o_Full = i_Push && (r_ByteCnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign o_Word = r_Word;

endmodule

// File: rtl/im_loader.sv
// ---------------------------------------------------------------------------
// im_loader
// Loads Count 32-bit words into instruction memory from a byte stream.
// Each word takes four byte transfers (RECV) and one write cycle (WRITE);
// a one-cycle FIN state reports Done.  Bad counts and aborts report Err.
// Ports:
//   Clk    : clock, all state changes on the rising edge
//   Reset  : synchronous active-high reset
//   bus    : im_loader_if slave modport (control, byte stream, write port,
//            status)
// ---------------------------------------------------------------------------
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH = IM_DEPTH,
    parameter int AW    = IM_AW
)
(
    input logic        Clk,
    input logic        Reset,
    im_loader_if.slave bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [1:0]    r_State;
    logic [1:0]    w_NextState;
    logic [AW:0]   r_Count;
    logic [AW-1:0] r_WordIdx;
    logic          r_Err;

    logic  w_InLoad;
    logic  w_Abort;
    logic  w_CountOk;
    logic  w_StartOk;
    logic  w_StartBad;
    logic  w_Accept;
    logic  w_LastWord;
    logic  w_PackClear;
    logic  w_Full;
    word_t w_Word;

    assign w_InLoad   = (r_State == ST_RECV) || (r_State == ST_WRITE);
    assign w_Abort    = w_InLoad && bus.Abort;
    assign w_CountOk  = (bus.Count != '0) && (bus.Count <= DEPTH_C);
    assign w_StartOk  = (r_State == ST_IDLE) && bus.Start && w_CountOk;
    assign w_StartBad = (r_State == ST_IDLE) && bus.Start && !w_CountOk;

    // Abort wins over a byte offered in the same cycle.
    assign w_Accept   = (r_State == ST_RECV) && bus.ByteValid && !bus.Abort;

    // Count >= 1 is guaranteed once latched, so Count-1 never underflows and
    // the index stops at DEPTH-1 at most.
    assign w_LastWord = ({1'b0, r_WordIdx} == (r_Count - (AW+1)'(1)));

    // A new word starts with an empty packer, both at load start and after
    // each write.
    assign w_PackClear = w_StartOk || (r_State == ST_WRITE);

    byte_packer u_packer (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_Clear (w_PackClear),
        .i_Push  (w_Accept),
        .i_Byte  (bus.ByteData),
        .o_Word  (w_Word),
        .o_Full  (w_Full)
    );

    // Next-state selection for the load sequence.
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            ST_IDLE: begin
                if (w_StartOk) begin
                    w_NextState = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.Abort) begin
                    w_NextState = ST_IDLE;
                end else if (w_Full) begin
                    w_NextState = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.Abort) begin
                    w_NextState = ST_IDLE;
                end else if (w_LastWord) begin
                    w_NextState = ST_FIN;
                end else begin
                    w_NextState = ST_RECV;
                end
            end
            default: begin
                w_NextState = ST_IDLE;
            end
        endcase
    end

    // State, latched count, word index and the registered Err pulse.
    // Reset drops any pending Err so a mid-load reset is silent.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_State   <= ST_IDLE;
            r_Count   <= '0;
            r_WordIdx <= '0;
            r_Err     <= 1'b0;
        end else begin
            r_State <= w_NextState;
            r_Err   <= w_StartBad || w_Abort;
            if (w_StartOk) begin
                r_Count   <= bus.Count;
                r_WordIdx <= '0;
            end else if ((r_State == ST_WRITE) && !bus.Abort && !w_LastWord) begin
                r_WordIdx <= r_WordIdx + AW'(1);
            end
        end
    end

    // Status and strobes are masked by Reset so they read zero for the whole
    // reset cycle, not only after the reset edge.
    assign bus.ByteReady = !Reset && (r_State == ST_RECV) && !bus.Abort;
    assign bus.WrEn      = !Reset && (r_State == ST_WRITE) && !bus.Abort;
    assign bus.WrAddr    = Reset ? '0 : r_WordIdx;
    assign bus.WrData    = w_Word;
    assign bus.Busy      = !Reset && (r_State != ST_IDLE);
    assign bus.Done      = !Reset && (r_State == ST_FIN);
    assign bus.Err       = !Reset && r_Err;

endmodule
